prbs7_err_detect: RTL and testbench



---
 rtl/prbs7_err_detect_pkg.sv | 24 ++
 rtl/prbs7_gen.sv | 35 +++
 rtl/prbs7_err_detect.sv | 155 +++++++++++++++
 tb/tb_prbs7_err_detect.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/prbs7_err_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prbs7_err_detect_pkg
// Brief   : Shared state encoding and PRBS-7 (x^7+x^6+1) constants.
// Revision: 1.0 - initial release
// ============================================================================
package prbs7_err_detect_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int c_SEED_W = 7;
    localparam int c_TAP_HI = 6;
    localparam int c_TAP_LO = 5;

    function automatic logic prbs7_pred(input logic [c_SEED_W-1:0] sr);
        return sr[c_TAP_HI] ^ sr[c_TAP_LO];
    endfunction

endpackage
`default_nettype wire

// File: rtl/prbs7_gen.sv
`default_nettype none
// ============================================================================
// Module  : prbs7_gen
// Brief   : 7-bit PRBS-7 LFSR, loadable from a serial input or free-running.
// Revision: 1.0 - initial release
// ============================================================================
module prbs7_gen
    import prbs7_err_detect_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                free_run,
    input  logic                din,
    output logic [c_SEED_W-1:0] sr,
    output logic                pred
);

    logic [c_SEED_W-1:0] r_sr;
    logic                w_in;

    assign pred = prbs7_pred(r_sr);
    assign w_in = free_run ? pred : din;
    assign sr   = r_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sr <= '0;
        end else if (en) begin
            r_sr <= {r_sr[c_SEED_W-2:0], w_in};
        end
    end

endmodule
`default_nettype wire

// File: rtl/prbs7_err_detect.sv
`default_nettype none
// ============================================================================
// Module  : prbs7_err_detect
// Brief   : PRBS-7 lock/verify checker with per-bit error pulse, loss-of-lock
//           window and saturating error counter.
// Revision: 1.0 - initial release
// ============================================================================
module prbs7_err_detect
    import prbs7_err_detect_pkg::*;
#(
    parameter int LOCK_CNT  = 16,
    parameter int WIN       = 64,
    parameter int LOSS_ERRS = 8,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          din,
    input  logic          din_valid,
    input  logic          clr_cnt,
    output logic          err_pulse,
    output logic          locked,
    output logic [CW-1:0] err_count
);

    localparam int c_FILL_W = $clog2(c_SEED_W);
    localparam int c_GOOD_W = $clog2(LOCK_CNT + 1);
    localparam int c_WIN_W  = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int c_MISS_W = $clog2(LOSS_ERRS + 1);

    localparam logic [c_FILL_W-1:0] c_FILL_LAST = c_FILL_W'(c_SEED_W - 1);
    localparam logic [c_GOOD_W-1:0] c_GOOD_LAST = c_GOOD_W'(LOCK_CNT - 1);
    localparam logic [c_WIN_W-1:0]  c_WIN_LAST  = c_WIN_W'(WIN - 1);
    localparam logic [c_MISS_W-1:0] c_MISS_LAST = c_MISS_W'(LOSS_ERRS - 1);

    state_t              r_state, w_state_nxt;
    logic [c_FILL_W-1:0] r_fill,  w_fill_nxt;
    logic [c_GOOD_W-1:0] r_good,  w_good_nxt;
    logic [c_WIN_W-1:0]  r_win,   w_win_nxt;
    logic [c_MISS_W-1:0] r_miss,  w_miss_nxt;
    logic [CW-1:0]       r_cnt;
    logic                r_pulse;

    logic [c_SEED_W-1:0] w_sr;
    logic                w_pred;
    logic                w_mismatch;
    logic                w_err;

    // Once locked the LFSR free-runs so a single flipped bit costs one error.
    prbs7_gen u_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (din_valid),
        .free_run (r_state == LOCKED),
        .din      (din),
        .sr       (w_sr),
        .pred     (w_pred)
    );

    assign w_mismatch = (din != w_pred);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_good_nxt  = r_good;
        w_win_nxt   = r_win;
        w_miss_nxt  = r_miss;
        w_err       = 1'b0;
        if (din_valid) begin
            case (r_state)
                HUNT: begin
                    if (r_fill == c_FILL_LAST) begin
                        w_state_nxt = VERIFY;
                        w_fill_nxt  = '0;
                        w_good_nxt  = '0;
                    end else begin
                        w_fill_nxt = r_fill + 1'b1;
                    end
                end
                VERIFY: begin
                    // All-zero history can never occur in a real PRBS-7 stream.
                    if (w_mismatch || (w_sr == '0)) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_good_nxt  = '0;
                    end else if (r_good == c_GOOD_LAST) begin
                        w_state_nxt = LOCKED;
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else begin
                        w_good_nxt = r_good + 1'b1;
                    end
                end
                LOCKED: begin
                    w_err = w_mismatch;
                    if (w_mismatch && (r_miss == c_MISS_LAST)) begin
                        w_state_nxt = HUNT;
                        w_fill_nxt  = '0;
                        w_good_nxt  = '0;
                        w_win_nxt   = '0;
                        w_miss_nxt  = '0;
                    end else if (r_win == c_WIN_LAST) begin
                        w_win_nxt  = '0;
                        w_miss_nxt = '0;
                    end else begin
                        w_win_nxt  = r_win + 1'b1;
                        w_miss_nxt = r_miss + c_MISS_W'(w_mismatch);
                    end
                end
                default: begin
                    w_state_nxt = HUNT;
                    w_fill_nxt  = '0;
                    w_good_nxt  = '0;
                    w_win_nxt   = '0;
                    w_miss_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= HUNT;
            r_fill  <= '0;
            r_good  <= '0;
            r_win   <= '0;
            r_miss  <= '0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_fill  <= w_fill_nxt;
            r_good  <= w_good_nxt;
            r_win   <= w_win_nxt;
            r_miss  <= w_miss_nxt;
            r_pulse <= w_err;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr_cnt) begin
            r_cnt <= '0;
        end else if (w_err && (r_cnt != {CW{1'b1}})) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign err_pulse = r_pulse;
    assign locked    = (r_state == LOCKED);
    assign err_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_prbs7_err_detect.sv
`default_nettype none
// ============================================================================
// Module  : tb_prbs7_err_detect
// Brief   : Directed self-checking bench for prbs7_err_detect.
// Revision: 1.0 - initial release
// ============================================================================
module tb_prbs7_err_detect;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din = 1'b0;
    logic        din_valid = 1'b0;
    logic        clr_cnt = 1'b0;
    logic        err_pulse, locked;
    logic [15:0] err_count;
    logic        err_pulse4, locked4;
    logic [3:0]  err_count4;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [6:0]  tx = 7'h7F;
    int          lock_bits = 0;
    bit          exp_lk = 0;

    always #5 clk = ~clk;

    prbs7_err_detect dut (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .err_pulse(err_pulse), .locked(locked),
        .err_count(err_count)
    );

    prbs7_err_detect #(.CW(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .clr_cnt(clr_cnt), .err_pulse(err_pulse4), .locked(locked4),
        .err_count(err_count4)
    );

    // Bench-side reference generator: x^7+x^6+1 from seed 7'h7F.
    task automatic send(input logic flip, input logic v);
        logic b;
        if (v) begin
            b   = tx[6] ^ tx[5];
            tx  = {tx[5:0], b};
            din = b ^ flip;
        end else begin
            din = 1'($urandom);
        end
        din_valid = v;
        @(posedge clk);
        #1;
        if (v && exp_lk) lock_bits++;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_lk = 0;
    endtask

    task automatic lock_up(input string tag);
        for (int i = 1; i <= 23; i++) begin
            send(1'b0, 1'b1);
            if (i == 22) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL %s_prelock: locked got %b expected 0", tag, locked);
                end
            end
        end
        n_cmp++;
        if (locked !== 1'b1) begin
            n_bad++;
            $display("FAIL %s_lock: locked got %b expected 1", tag, locked);
        end
        exp_lk = 1;
        lock_bits = 0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        n_cmp++;
        if (err_pulse !== 1'b0 || locked !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_flags: pulse/locked got %b%b expected 00", err_pulse, locked);
        end
        n_cmp++;
        if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
            n_bad++;
            $display("FAIL reset_count: got %0d/%0d expected 0/0", err_count, err_count4);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_clean_lock();
        int pulses = 0;
        exp_lk = 0;
        for (int i = 1; i <= 200; i++) begin
            send(1'b0, 1'b1);
            if (err_pulse) pulses++;
            if (i == 22) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL clean_prelock: locked got %b expected 0", locked);
                end
            end
            if (i == 23) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL clean_lock: locked got %b expected 1", locked);
                end
                exp_lk = 1;
                lock_bits = 0;
            end
        end
        n_cmp++;
        if (pulses != 0 || err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL clean_errors: pulses %0d count %0d expected 0 0", pulses, err_count);
        end
    endtask

    task automatic test_flips();
        int   pulses = 0;
        logic f;
        for (int i = 1; i <= 120; i++) begin
            f = (i == 40 || i == 41 || i == 100);
            send(f, 1'b1);
            if (err_pulse) pulses++;
            if (f || i == 42) begin
                n_cmp++;
                if (err_pulse !== f) begin
                    n_bad++;
                    $display("FAIL flip_pulse_%0d: got %b expected %b", i, err_pulse, f);
                end
            end
        end
        n_cmp++;
        if (pulses != 3 || err_count !== 16'd3 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL flip_totals: pulses %0d count %0d locked %b expected 3 3 1",
                     pulses, err_count, locked);
        end
    endtask

    task automatic test_loss();
        clr_cnt = 1'b1;
        send(1'b0, 1'b0);
        clr_cnt = 1'b0;
        n_cmp++;
        if (err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL loss_clr: count got %0d expected 0", err_count);
        end
        for (int i = 0; i < 64 && (lock_bits % 64) != 0; i++) send(1'b0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            send(1'b1, 1'b1);
            n_cmp++;
            if (err_pulse !== 1'b1 || locked !== (k < 7)) begin
                n_bad++;
                $display("FAIL loss_err_%0d: pulse %b locked %b expected 1 %b",
                         k, err_pulse, locked, (k < 7));
            end
        end
        exp_lk = 0;
        lock_up("loss_relock");
        n_cmp++;
        if (err_count !== 16'd8) begin
            n_bad++;
            $display("FAIL loss_count: got %0d expected 8", err_count);
        end
    endtask

    task automatic test_reset_mid_locked();
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (locked !== 1'b0 || err_pulse !== 1'b0 || err_count !== 16'd0) begin
            n_bad++;
            $display("FAIL async_reset: locked %b pulse %b count %0d expected 0 0 0",
                     locked, err_pulse, err_count);
        end
        #2 rst_n = 1'b1;
        exp_lk = 0;
        lock_up("rst_relock");
    endtask

    task automatic test_valid_toggle();
        int pulses = 0;
        do_reset();
        for (int i = 1; i <= 23; i++) begin
            send(1'b0, 1'b1);
            if (i == 23) begin
                n_cmp++;
                if (locked !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tog_lock: locked got %b expected 1", locked);
                end
                exp_lk = 1;
            end
            send(1'b0, 1'b0);
            if (i == 22) begin
                n_cmp++;
                if (locked !== 1'b0) begin
                    n_bad++;
                    $display("FAIL tog_prelock: locked got %b expected 0", locked);
                end
            end
        end
        for (int i = 0; i < 20; i++) begin
            send(i == 5, 1'b1);
            if (err_pulse) pulses++;
            if (i == 5) begin
                n_cmp++;
                if (err_pulse !== 1'b1) begin
                    n_bad++;
                    $display("FAIL tog_pulse: got %b expected 1", err_pulse);
                end
            end
            send(1'b0, 1'b0);
            if (err_pulse) pulses++;
        end
        n_cmp++;
        if (pulses != 1 || err_count !== 16'd1 || locked !== 1'b1) begin
            n_bad++;
            $display("FAIL tog_totals: pulses %0d count %0d locked %b expected 1 1 1",
                     pulses, err_count, locked);
        end
    endtask

    task automatic test_all_zero();
        int lk = 0;
        int pulses = 0;
        do_reset();
        for (int i = 0; i < 60; i++) begin
            din = 1'b0;
            din_valid = 1'b1;
            @(posedge clk);
            #1;
            if (locked) lk++;
            if (err_pulse) pulses++;
        end
        n_cmp++;
        if (lk != 0 || pulses != 0) begin
            n_bad++;
            $display("FAIL zero_stream: locked cycles %0d pulses %0d expected 0 0", lk, pulses);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        lock_up("sat_lock");
        for (int e = 1; e <= 20; e++) begin
            for (int j = 0; j < 15; j++) send(1'b0, 1'b1);
            send(1'b1, 1'b1);
            if (e == 16) begin
                n_cmp++;
                if (err_count4 !== 4'd15) begin
                    n_bad++;
                    $display("FAIL sat_hold16: count4 got %0d expected 15", err_count4);
                end
            end
        end
        n_cmp++;
        if (err_count4 !== 4'd15 || err_count !== 16'd20) begin
            n_bad++;
            $display("FAIL sat_counts: got %0d/%0d expected 15/20", err_count4, err_count);
        end
        n_cmp++;
        if (locked !== 1'b1 || locked4 !== 1'b1) begin
            n_bad++;
            $display("FAIL sat_locked: got %b%b expected 11", locked, locked4);
        end
        for (int j = 0; j < 15; j++) send(1'b0, 1'b1);
        clr_cnt = 1'b1;
        send(1'b1, 1'b1);
        clr_cnt = 1'b0;
        n_cmp++;
        if (err_pulse !== 1'b1 || err_pulse4 !== 1'b1) begin
            n_bad++;
            $display("FAIL clr_err_pulse: got %b%b expected 11", err_pulse, err_pulse4);
        end
        n_cmp++;
        if (err_count !== 16'd0 || err_count4 !== 4'd0) begin
            n_bad++;
            $display("FAIL clr_err_count: got %0d/%0d expected 0/0", err_count, err_count4);
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_flips();
        test_loss();
        test_reset_mid_locked();
        test_valid_toggle();
        test_all_zero();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
